// File: rtl/mem_write_checker.sv
`default_nettype none
// ============================================================================
// Module      : mem_write_checker
// Description : Self-check monitor for CPU data-memory stores. Compares each
//               store (memwrite, dataadr, writedata) in order against a
//               loaded table of expected (address, data) pairs. Stores that
//               fall in [IGN_LO, IGN_HI] and do not match the current entry
//               are counted and skipped. Reports pass, fail (mismatch) or
//               fail (timeout) with diagnostics.
// Ports       : clk, reset (async, active-high)
//               memwrite/dataadr/writedata  - observed store bus
//               exp_we/exp_idx/exp_adr/exp_data - table load port
//               exp_count/start              - arm the checker
//               done/pass/fail/err_code      - verdict (registered)
//               fail_idx/fail_adr/fail_data  - failure diagnostics
//               match_cnt/ign_cnt            - progress counters
// Revision    : 1.0 - initial release
// ============================================================================
module mem_write_checker #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 8,
    parameter int IGN_LO  = 80,
    parameter int IGN_HI  = 80,
    parameter int TIMEOUT = 1000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       memwrite,
    input  logic [WIDTH-1:0]           dataadr,
    input  logic [WIDTH-1:0]           writedata,
    input  logic                       exp_we,
    input  logic [$clog2(DEPTH)-1:0]   exp_idx,
    input  logic [WIDTH-1:0]           exp_adr,
    input  logic [WIDTH-1:0]           exp_data,
    input  logic [$clog2(DEPTH):0]     exp_count,
    input  logic                       start,
    output logic                       done,
    output logic                       pass,
    output logic                       fail,
    output logic [1:0]                 err_code,
    output logic [$clog2(DEPTH)-1:0]   fail_idx,
    output logic [WIDTH-1:0]           fail_adr,
    output logic [WIDTH-1:0]           fail_data,
    output logic [$clog2(DEPTH):0]     match_cnt,
    output logic [7:0]                 ign_cnt
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] c_err_mismatch = 2'd1;
    localparam logic [1:0] c_err_timeout  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_PASS  = 2'd2,
        S_FAIL  = 2'd3
    } state_t;

    state_t            r_state;
    logic [WIDTH-1:0]  r_tab_adr  [DEPTH];
    logic [WIDTH-1:0]  r_tab_data [DEPTH];
    logic [CW-1:0]     r_count;
    logic [IW-1:0]     r_ptr;
    logic [TW-1:0]     r_cyc;

    logic [CW-1:0]     w_count_clamped;
    logic              w_match;
    logic              w_last;
    logic              w_in_ign;
    logic              w_timeout;

    assign w_count_clamped = (exp_count > CW'(DEPTH)) ? CW'(DEPTH) : exp_count;
    assign w_match   = (dataadr == r_tab_adr[r_ptr]) && (writedata == r_tab_data[r_ptr]);
    assign w_last    = ({1'b0, r_ptr} == (r_count - CW'(1)));
    assign w_in_ign  = (dataadr >= WIDTH'(IGN_LO)) && (dataadr <= WIDTH'(IGN_HI));
    assign w_timeout = (r_cyc == TW'(TIMEOUT - 1));

    // Expected-write table: frozen while a check is in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_tab_adr[i]  <= '0;
                r_tab_data[i] <= '0;
            end
        end else if (exp_we && (r_state != S_ARMED)) begin
            r_tab_adr[exp_idx]  <= exp_adr;
            r_tab_data[exp_idx] <= exp_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_ptr     <= '0;
            r_cyc     <= '0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail      <= 1'b0;
            err_code  <= '0;
            fail_idx  <= '0;
            fail_adr  <= '0;
            fail_data <= '0;
            match_cnt <= '0;
            ign_cnt   <= '0;
        end else begin
            case (r_state)
                S_ARMED: begin
                    if (r_count == '0) begin
                        r_state <= S_PASS;
                        done    <= 1'b1;
                        pass    <= 1'b1;
                    end else if (memwrite && w_match) begin
                        r_ptr     <= r_ptr + IW'(1);
                        match_cnt <= match_cnt + CW'(1);
                        if (w_last) begin
                            r_state <= S_PASS;
                            done    <= 1'b1;
                            pass    <= 1'b1;
                        end else if (w_timeout) begin
                            // Non-final match does not rescue an expired budget.
                            r_state  <= S_FAIL;
                            done     <= 1'b1;
                            fail     <= 1'b1;
                            err_code <= c_err_timeout;
                            fail_idx <= r_ptr + IW'(1);
                        end else begin
                            r_cyc <= r_cyc + TW'(1);
                        end
                    end else if (memwrite && !w_in_ign) begin
                        r_state   <= S_FAIL;
                        done      <= 1'b1;
                        fail      <= 1'b1;
                        err_code  <= c_err_mismatch;
                        fail_idx  <= r_ptr;
                        fail_adr  <= dataadr;
                        fail_data <= writedata;
                    end else begin
                        // Idle cycle or ignored store; both still consume budget.
                        if (memwrite && (ign_cnt != 8'hFF)) begin
                            ign_cnt <= ign_cnt + 8'd1;
                        end
                        if (w_timeout) begin
                            r_state  <= S_FAIL;
                            done     <= 1'b1;
                            fail     <= 1'b1;
                            err_code <= c_err_timeout;
                            fail_idx <= r_ptr;
                        end else begin
                            r_cyc <= r_cyc + TW'(1);
                        end
                    end
                end
                default: begin
                    // IDLE, PASS and FAIL all re-arm on start.
                    if (start) begin
                        r_state   <= S_ARMED;
                        r_count   <= w_count_clamped;
                        r_ptr     <= '0;
                        r_cyc     <= '0;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        fail      <= 1'b0;
                        err_code  <= '0;
                        fail_idx  <= '0;
                        fail_adr  <= '0;
                        fail_data <= '0;
                        match_cnt <= '0;
                        ign_cnt   <= '0;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_write_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_write_checker
// Description : Scenario bench for mem_write_checker (TIMEOUT=20). Each
//               scenario pushes its expected verdict to a queue and pops it
//               when the checker raises done.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_write_checker;

    localparam int WIDTH = 32;
    localparam int DEPTH = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              memwrite;
    logic [WIDTH-1:0]  dataadr;
    logic [WIDTH-1:0]  writedata;
    logic              exp_we;
    logic [2:0]        exp_idx;
    logic [WIDTH-1:0]  exp_adr;
    logic [WIDTH-1:0]  exp_data;
    logic [3:0]        exp_count;
    logic              start;
    logic              done;
    logic              pass;
    logic              fail;
    logic [1:0]        err_code;
    logic [2:0]        fail_idx;
    logic [WIDTH-1:0]  fail_adr;
    logic [WIDTH-1:0]  fail_data;
    logic [3:0]        match_cnt;
    logic [7:0]        ign_cnt;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic        done;
        logic        pass;
        logic        fail;
        logic [1:0]  err;
        logic [2:0]  idx;
        logic [31:0] adr;
        logic [31:0] data;
        logic [3:0]  mc;
        logic [7:0]  ign;
    } res_t;

    res_t sb[$];

    mem_write_checker #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .IGN_LO(80), .IGN_HI(80), .TIMEOUT(20)
    ) dut (
        .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
        .writedata(writedata), .exp_we(exp_we), .exp_idx(exp_idx),
        .exp_adr(exp_adr), .exp_data(exp_data), .exp_count(exp_count),
        .start(start), .done(done), .pass(pass), .fail(fail),
        .err_code(err_code), .fail_idx(fail_idx), .fail_adr(fail_adr),
        .fail_data(fail_data), .match_cnt(match_cnt), .ign_cnt(ign_cnt)
    );

    always #5 clk = ~clk;

    function automatic res_t mk(input logic p, input logic f, input logic [1:0] e,
                                input logic [2:0] i, input logic [31:0] a,
                                input logic [31:0] d, input logic [3:0] m,
                                input logic [7:0] g);
        return '{done: p | f, pass: p, fail: f, err: e, idx: i, adr: a, data: d, mc: m, ign: g};
    endfunction

    function automatic res_t observe();
        return '{done: done, pass: pass, fail: fail, err: err_code, idx: fail_idx,
                 adr: fail_adr, data: fail_data, mc: match_cnt, ign: ign_cnt};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int idx, input logic [31:0] a, input logic [31:0] d);
        exp_we = 1'b1; exp_idx = 3'(idx); exp_adr = a; exp_data = d;
        tick();
        exp_we = 1'b0;
    endtask

    task automatic arm(input int cnt);
        exp_count = 4'(cnt); start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        memwrite = 1'b1; dataadr = a; writedata = d;
        tick();
        memwrite = 1'b0;
    endtask

    // Bounded wait for a verdict; n = edges waited.
    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        res_t o;
        reset = 1'b1;
        repeat (3) tick();
        o = observe();
        checks++;
        if (o !== '0) begin
            failures++;
            $display("FAIL reset_state: got %h required 0", o);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_ignore();
        res_t r, o;
        int n;
        load(0, 84, 7);
        arm(1);
        sb.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1));
        store(80, 32'h55);
        checks++;
        if (done !== 1'b0 || ign_cnt !== 8'd1) begin
            failures++;
            $display("FAIL ignore_mid: done=%b ign=%0d required done=0 ign=1", done, ign_cnt);
        end
        store(84, 7);
        wait_done(n);
        r = sb.pop_front(); o = observe();
        checks++;
        if (o !== r) begin
            failures++;
            $display("FAIL ignore_pass: got %h required %h", o, r);
        end
    endtask

    task automatic test_mismatch();
        res_t r, o;
        int n;
        arm(1);
        sb.push_back(mk(0, 1, 1, 0, 84, 8, 0, 0));
        store(84, 8);
        wait_done(n);
        r = sb.pop_front(); o = observe();
        checks++;
        if (o !== r) begin
            failures++;
            $display("FAIL mismatch: got %h required %h", o, r);
        end
    endtask

    task automatic test_order();
        res_t r, o;
        int n;
        load(0, 100, 1); load(1, 104, 2); load(2, 108, 3);
        arm(3);
        sb.push_back(mk(1, 0, 0, 0, 0, 0, 3, 0));
        store(100, 1);
        checks++;
        if (match_cnt !== 4'd1 || done !== 1'b0) begin
            failures++;
            $display("FAIL order_progress: match=%0d done=%b required 1/0", match_cnt, done);
        end
        store(104, 2); store(108, 3);
        wait_done(n);
        r = sb.pop_front(); o = observe();
        checks++;
        if (o !== r) begin
            failures++;
            $display("FAIL order_pass: got %h required %h", o, r);
        end
        arm(3);
        sb.push_back(mk(0, 1, 1, 1, 108, 3, 1, 0));
        store(100, 1); store(108, 3);
        wait_done(n);
        r = sb.pop_front(); o = observe();
        checks++;
        if (o !== r) begin
            failures++;
            $display("FAIL order_swap: got %h required %h", o, r);
        end
    endtask

    task automatic test_timeout();
        res_t r, o;
        int n;
        arm(3);
        sb.push_back(mk(0, 1, 2, 0, 0, 0, 0, 0));
        wait_done(n);
        checks++;
        if (n !== 20) begin
            failures++;
            $display("FAIL timeout_latency: got %0d edges required 20", n);
        end
        r = sb.pop_front(); o = observe();
        checks++;
        if (o !== r) begin
            failures++;
            $display("FAIL timeout: got %h required %h", o, r);
        end
    endtask

    task automatic test_timeout_edge();
        res_t r, o;
        int n;
        load(0, 84, 7);
        arm(1);
        sb.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0));
        repeat (19) tick();
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL edge_early: done=%b required 0", done);
        end
        store(84, 7);
        wait_done(n);
        r = sb.pop_front(); o = observe();
        checks++;
        if (o !== r) begin
            failures++;
            $display("FAIL edge_last_store: got %h required %h", o, r);
        end
        arm(0);
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL zero_armed: done=%b required 0", done);
        end
        sb.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
        tick();
        r = sb.pop_front(); o = observe();
        checks++;
        if (o !== r) begin
            failures++;
            $display("FAIL zero_count: got %h required %h", o, r);
        end
    endtask

    task automatic test_clamp();
        res_t r, o;
        int n;
        for (int i = 0; i < DEPTH; i++) load(i, 32'(200 + 4 * i), 32'(i + 1));
        arm(15);
        sb.push_back(mk(1, 0, 0, 0, 0, 0, 8, 0));
        for (int i = 0; i < DEPTH; i++) store(32'(200 + 4 * i), 32'(i + 1));
        wait_done(n);
        r = sb.pop_front(); o = observe();
        checks++;
        if (o !== r) begin
            failures++;
            $display("FAIL clamp: got %h required %h", o, r);
        end
    endtask

    task automatic test_armed_ignores();
        res_t r, o;
        int n;
        load(0, 84, 7);
        arm(1);
        store(80, 5);
        // start and exp_we while ARMED must both be dropped
        exp_count = 4'd0; start = 1'b1;
        exp_we = 1'b1; exp_idx = 3'd0; exp_adr = 300; exp_data = 9;
        tick();
        start = 1'b0; exp_we = 1'b0;
        sb.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1));
        store(84, 7);
        wait_done(n);
        r = sb.pop_front(); o = observe();
        checks++;
        if (o !== r) begin
            failures++;
            $display("FAIL armed_ignores: got %h required %h", o, r);
        end
    endtask

    task automatic test_reset_mid();
        res_t r, o;
        int n;
        arm(1);
        store(80, 0);
        reset = 1'b1;
        #1;
        o = observe();
        checks++;
        if (o !== '0) begin
            failures++;
            $display("FAIL async_reset: got %h required 0", o);
        end
        #1;
        reset = 1'b0;
        // table was cleared, so entry 0 no longer holds (84,7)
        arm(1);
        sb.push_back(mk(0, 1, 1, 0, 84, 7, 0, 0));
        store(84, 7);
        wait_done(n);
        r = sb.pop_front(); o = observe();
        checks++;
        if (o !== r) begin
            failures++;
            $display("FAIL table_cleared: got %h required %h", o, r);
        end
        load(0, 84, 7);
        arm(1);
        sb.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0));
        store(84, 7);
        wait_done(n);
        r = sb.pop_front(); o = observe();
        checks++;
        if (o !== r) begin
            failures++;
            $display("FAIL rearm_after_reset: got %h required %h", o, r);
        end
    endtask

    initial begin
        reset = 1'b1; memwrite = 1'b0; dataadr = '0; writedata = '0;
        exp_we = 1'b0; exp_idx = '0; exp_adr = '0; exp_data = '0;
        exp_count = '0; start = 1'b0;
        test_reset();
        test_ignore();
        test_mismatch();
        test_order();
        test_timeout();
        test_timeout_edge();
        test_clamp();
        test_armed_ignores();
        test_reset_mid();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d left required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
